// File: rtl/pipe_sched.sv
// Pipeline sequencing controller: one fixed-priority source for every PC / IF/ID /
// ID/EX / EX/MEM write-enable and flush, plus MDU tracking and interrupt entry.
module pipe_sched #(
    parameter int unsigned MDU_LATENCY = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic Stall,
    input  logic ID_Jump,
    input  logic ID_BranchTaken,
    input  logic ID_MDUUse,
    input  logic EX_MDUStart,
    input  logic MEM_Wait,
    input  logic IRQ,
    output logic PC_Write,
    output logic IFID_Write,
    output logic IFID_Flush,
    output logic IDEX_Write,
    output logic IDEX_Flush,
    output logic EXMEM_Write,
    output logic PC_ExcSel,
    output logic IRQ_Ack,
    output logic MDU_Busy,
    output logic MDU_Done
);

    typedef enum logic {
        RUN = 1'b0,
        MDU = 1'b1
    } state_t;

    localparam logic [5:0] CNT_LOAD = 6'(MDU_LATENCY - 1);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       irq_pend_q, irq_pend_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    assign MDU_Busy = busy_q;
    assign MDU_Done = done_q;

    // Pipeline controls; reset forces the defaults since the pipeline registers reset themselves.
    always_comb begin
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Write  = 1'b1;
        IDEX_Flush  = 1'b0;
        EXMEM_Write = 1'b1;
        PC_ExcSel   = 1'b0;
        IRQ_Ack     = 1'b0;
        if (!reset) begin
            if (MEM_Wait) begin
                PC_Write    = 1'b0;
                IFID_Write  = 1'b0;
                IDEX_Write  = 1'b0;
                EXMEM_Write = 1'b0;
            end else if (state_q == RUN && irq_pend_q && !Stall) begin
                PC_ExcSel  = 1'b1;
                IFID_Flush = 1'b1;
                IRQ_Ack    = 1'b1;
            end else if ((state_q == MDU && ID_MDUUse) || Stall) begin
                PC_Write   = 1'b0;
                IFID_Write = 1'b0;
                IDEX_Flush = 1'b1;
            end else if (ID_Jump || ID_BranchTaken) begin
                IFID_Flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        // Set wins over clear so an IRQ in the take cycle stays pending.
        irq_pend_d = IRQ | (irq_pend_q & ~IRQ_Ack);
        if (!MEM_Wait) begin
            unique case (state_q)
                RUN: begin
                    if (EX_MDUStart) begin
                        state_d = MDU;
                        cnt_d   = CNT_LOAD;
                        busy_d  = 1'b1;
                    end
                end
                MDU: begin
                    if (cnt_q == '0) begin
                        state_d = RUN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            irq_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            irq_pend_q <= irq_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_pipe_sched.sv
// Directed bench for pipe_sched with MDU_LATENCY=4; expected output vectors are hand-computed.
module tb_pipe_sched;

    logic clk;
    logic reset, Stall, ID_Jump, ID_BranchTaken, ID_MDUUse, EX_MDUStart, MEM_Wait, IRQ;
    logic PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write;
    logic PC_ExcSel, IRQ_Ack, MDU_Busy, MDU_Done;

    int n_cmp;
    int n_err;

    // Input vector: {reset, Stall, ID_Jump, ID_BranchTaken, ID_MDUUse, EX_MDUStart, MEM_Wait, IRQ}
    localparam logic [7:0] I_IDLE = 8'h00;
    localparam logic [7:0] I_RST  = 8'h80;
    localparam logic [7:0] I_STL  = 8'h40;
    localparam logic [7:0] I_JMP  = 8'h20;
    localparam logic [7:0] I_BR   = 8'h10;
    localparam logic [7:0] I_USE  = 8'h08;
    localparam logic [7:0] I_STRT = 8'h04;
    localparam logic [7:0] I_MW   = 8'h02;
    localparam logic [7:0] I_IRQ  = 8'h01;

    // Output vector: {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
    //                 EXMEM_Write, PC_ExcSel, IRQ_Ack, MDU_Busy, MDU_Done}
    localparam logic [9:0] E_DEF   = 10'b1101010000;
    localparam logic [9:0] E_STL   = 10'b0001110000;
    localparam logic [9:0] E_BR    = 10'b1111010000;
    localparam logic [9:0] E_MW    = 10'b0000000000;
    localparam logic [9:0] E_TAKE  = 10'b1111011100;
    localparam logic [9:0] E_ILCK  = 10'b0001110010;
    localparam logic [9:0] E_MWB   = 10'b0000000010;
    localparam logic [9:0] E_DONE  = 10'b1101010001;
    localparam logic [9:0] E_TAKED = 10'b1111011101;
    localparam logic [9:0] E_RSTB  = 10'b1101010010;

    pipe_sched #(.MDU_LATENCY(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .Stall          (Stall),
        .ID_Jump        (ID_Jump),
        .ID_BranchTaken (ID_BranchTaken),
        .ID_MDUUse      (ID_MDUUse),
        .EX_MDUStart    (EX_MDUStart),
        .MEM_Wait       (MEM_Wait),
        .IRQ            (IRQ),
        .PC_Write       (PC_Write),
        .IFID_Write     (IFID_Write),
        .IFID_Flush     (IFID_Flush),
        .IDEX_Write     (IDEX_Write),
        .IDEX_Flush     (IDEX_Flush),
        .EXMEM_Write    (EXMEM_Write),
        .PC_ExcSel      (PC_ExcSel),
        .IRQ_Ack        (IRQ_Ack),
        .MDU_Busy       (MDU_Busy),
        .MDU_Done       (MDU_Done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle: drive inputs just after the edge, compare all outputs mid-cycle.
    task automatic cyc(input string tag, input logic [7:0] in, input logic [9:0] exp);
        logic [9:0] obs;
        @(posedge clk);
        #1;
        {reset, Stall, ID_Jump, ID_BranchTaken, ID_MDUUse, EX_MDUStart, MEM_Wait, IRQ} = in;
        #1;
        obs = {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
               EXMEM_Write, PC_ExcSel, IRQ_Ack, MDU_Busy, MDU_Done};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        {reset, Stall, ID_Jump, ID_BranchTaken, ID_MDUUse, EX_MDUStart, MEM_Wait, IRQ} = I_RST;

        cyc("reset0", I_RST, E_DEF);
        cyc("reset1", I_RST, E_DEF);
        cyc("idle", I_IDLE, E_DEF);

        // Load-use stall lasts exactly one cycle
        cyc("stall", I_STL, E_STL);
        cyc("stall_after", I_IDLE, E_DEF);

        // Redirects, and stall beating a branch
        cyc("branch", I_BR, E_BR);
        cyc("jump", I_JMP, E_BR);
        cyc("branch_stall", I_BR | I_STL, E_STL);
        cyc("redir_after", I_IDLE, E_DEF);

        // MDU, no MEM_Wait: start at c10, done at c15
        cyc("mdu_c10", I_STRT, E_DEF);
        cyc("mdu_c11", I_USE, E_ILCK);
        cyc("mdu_c12", I_USE, E_ILCK);
        cyc("mdu_c13", I_USE, E_ILCK);
        cyc("mdu_c14", I_USE, E_ILCK);
        cyc("mdu_c15", I_USE, E_DONE);
        cyc("mdu_c16", I_IDLE, E_DEF);

        // MDU with one MEM_Wait cycle at c12: done moves to c16
        cyc("mdw_c10", I_STRT, E_DEF);
        cyc("mdw_c11", I_USE, E_ILCK);
        cyc("mdw_c12", I_USE | I_MW, E_MWB);
        cyc("mdw_c13", I_USE, E_ILCK);
        cyc("mdw_c14", I_USE, E_ILCK);
        cyc("mdw_c15", I_USE, E_ILCK);
        cyc("mdw_c16", I_USE, E_DONE);
        cyc("mdw_c17", I_IDLE, E_DEF);

        // IRQ during MDU is held until return to RUN at c15
        cyc("mirq_c10", I_STRT, E_DEF);
        cyc("mirq_c11", I_USE, E_ILCK);
        cyc("mirq_c12", I_USE | I_IRQ, E_ILCK);
        cyc("mirq_c13", I_USE, E_ILCK);
        cyc("mirq_c14", I_USE, E_ILCK);
        cyc("mirq_c15", I_USE, E_TAKED);
        cyc("mirq_c16", I_IDLE, E_DEF);

        // IRQ vs stall; second IRQ in the take cycle gives another take
        cyc("istl_c5", I_IRQ, E_DEF);
        cyc("istl_c6", I_STL, E_STL);
        cyc("istl_c7", I_STL, E_STL);
        cyc("istl_c8", I_IRQ, E_TAKE);
        cyc("istl_c9", I_IDLE, E_TAKE);
        cyc("istl_c10", I_IDLE, E_DEF);

        // MEM_Wait outranks a pending interrupt; take follows once it drops
        cyc("imw_irq", I_IRQ | I_JMP, E_BR);
        cyc("imw_wait", I_MW | I_STL, E_MW);
        cyc("imw_take", I_JMP, E_TAKE);
        cyc("imw_after", I_IDLE, E_DEF);

        // Reset mid-MDU at c13: busy drops at c14, no done, pending IRQ lost
        cyc("rmdu_c10", I_STRT, E_DEF);
        cyc("rmdu_c11", I_USE, E_ILCK);
        cyc("rmdu_c12", I_USE | I_IRQ, E_ILCK);
        cyc("rmdu_c13", I_RST | I_USE, E_RSTB);
        cyc("rmdu_c14", I_USE, E_DEF);
        cyc("rmdu_c15", I_IDLE, E_DEF);
        cyc("rmdu_c16", I_IDLE, E_DEF);
        cyc("rmdu_c17", I_IDLE, E_DEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_sched.md
# pipe_sched

Pipeline sequencing controller for the 5-stage MIPS core. Combines the ID-stage hazard stall, ID-resolved jump/branch redirects, data-memory wait, the multi-cycle multiply/divide unit (MDU) and external interrupt entry. Produces every pipeline-register write-enable and flush, with one fixed priority order. Sits beside the hazard unit and drives the PC, IF/ID, ID/EX and EX/MEM register controls.

## Interface
- MDU_LATENCY, 32, cycles from MDU start until HI/LO valid; legal range 2..63
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- Stall  in  1  load-use/branch-operand hazard from the hazard unit
- ID_Jump  in  1  j/jal/jr/jalr resolved in ID
- ID_BranchTaken  in  1  branch resolved taken in ID
- ID_MDUUse  in  1  instruction in ID is mult/div/mfhi/mflo/mthi/mtlo
- EX_MDUStart  in  1  mult/div entering the MDU from EX this cycle
- MEM_Wait  in  1  data memory not ready
- IRQ  in  1  external interrupt request, one-cycle pulse
- PC_Write  out  1  PC register load enable
- IFID_Write  out  1  IF/ID load enable
- IFID_Flush  out  1  IF/ID loads a nop
- IDEX_Write  out  1  ID/EX load enable
- IDEX_Flush  out  1  ID/EX loads a bubble
- EXMEM_Write  out  1  EX/MEM load enable
- PC_ExcSel  out  1  PC loads the exception vector 0x80000004
- IRQ_Ack  out  1  one-cycle pulse, interrupt taken
- MDU_Busy  out  1  registered; MDU operation in flight
- MDU_Done  out  1  registered one-cycle pulse when HI/LO become valid

## Operation
- State: FSM {RUN, MDU}. MDU countdown counter, 6 bits. irq_pend flag.
- Outputs are combinational from state, irq_pend and inputs, except MDU_Busy and MDU_Done, which are registered.
- Default outputs: all *_Write=1; all flushes, PC_ExcSel and IRQ_Ack =0.
- Priority within a cycle, highest first:
  1. MEM_Wait: PC_Write, IFID_Write, IDEX_Write and EXMEM_Write =0. No flushes. Counter, FSM and irq_pend do not advance, but an IRQ pulse still sets irq_pend.
  2. Interrupt take, when state=RUN, irq_pend=1 and Stall=0: PC_ExcSel=1, IFID_Flush=1, IRQ_Ack=1. irq_pend clears. The jump/branch in ID still completes, because its redirect is overridden by the vector.
  3. MDU interlock, when state=MDU and ID_MDUUse=1: PC_Write=0, IFID_Write=0, IDEX_Flush=1.
  4. Stall: PC_Write=0, IFID_Write=0, IDEX_Flush=1.
  5. ID_Jump or ID_BranchTaken: IFID_Flush=1 (squash the wrong-path fetch).
- RUN -> MDU: when EX_MDUStart=1 and MEM_Wait=0. The counter loads MDU_LATENCY-1 and MDU_Busy goes 1 the next cycle.
- In MDU: the counter decrements each cycle MEM_Wait=0. In the cycle where counter==0 and MEM_Wait=0:
  - next state is RUN;
  - MDU_Busy goes 0 and MDU_Done pulses 1 for one cycle.
- An ID_MDUUse instruction is released in the first cycle state=RUN.
- Interrupts are not taken while state=MDU; irq_pend holds until return to RUN.
- EX_MDUStart while state=MDU is protocol-illegal (the interlock prevents it) and is ignored.
- irq_pend is set by IRQ. A new IRQ arriving in the take cycle leaves irq_pend=1, because set wins over clear.

## Timing
- Reset (clk edge with reset=1): state=RUN, counter=0, irq_pend=0, MDU_Busy=0, MDU_Done=0.
- While reset=1, combinational outputs are the defaults. Pipeline registers reset themselves.
- Stall and redirect controls have zero latency (same cycle as the input).
- IRQ pulse at cycle n: earliest take is cycle n+1.
- MDU with EX_MDUStart at cycle n and no MEM_Wait:
  - MDU_Busy=1 for cycles n+1..n+MDU_LATENCY;
  - MDU_Done=1 at cycle n+MDU_LATENCY+1;
  - a dependent ID_MDUUse is released in cycle n+MDU_LATENCY+1.
- Each MEM_Wait cycle in MDU state extends the above by one cycle.
- Reset mid-MDU: returns to RUN at once. MDU_Done does not pulse, and irq_pend is lost.

## Test plan
- Load-use: Stall=1 for 1 cycle -> PC_Write=0, IFID_Write=0, IDEX_Flush=1 that cycle only. The next cycle has defaults.
- Branch and jump: ID_BranchTaken=1 -> IFID_Flush=1, PC_Write=1. Repeat with Stall=1 in the same cycle -> stall outputs win, IFID_Flush=0.
- MDU, MDU_LATENCY=4: EX_MDUStart at cycle 10, ID_MDUUse=1 from cycle 11:
  - MDU_Busy=1 at cycles 11-14;
  - IDEX_Flush=1 at cycles 11-14;
  - MDU_Done=1 at cycle 15, with PC_Write=1 at cycle 15.
  - Repeat with MEM_Wait=1 at cycle 12 -> MDU_Done moves to cycle 16, and all *_Write=0 at cycle 12.
- Interrupt during MDU: IRQ at cycle 12 of the previous case -> no IRQ_Ack until cycle 15. At cycle 15: IRQ_Ack=1, PC_ExcSel=1, IFID_Flush=1.
- Interrupt vs stall: IRQ at cycle 5, Stall=1 at cycles 6-7 -> take at cycle 8. A second IRQ at cycle 8 -> another IRQ_Ack at cycle 9.
- Reset at cycle 13 of the MDU case -> cycle 14 has MDU_Busy=0, and MDU_Done never pulses.
